// File: rtl/hidden_ram_if.sv
// Bundle of requester, scoreboard and RAM-port signals for the hidden-unit
// activation RAM controller.
interface hidden_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              layer_clr;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W:0]   wr_count;
  logic              all_written;

  modport slave (
    input  layer_clr, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output wr_gnt, rd_gnt, rd_valid, rd_data, ram_data, ram_addr, ram_we,
           wr_count, all_written
  );

  modport master (
    output layer_clr, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, ram_data, ram_addr, ram_we,
           wr_count, all_written
  );
endinterface

// File: rtl/hidden_ram_ctrl.sv
// Round-robin arbiter for the single-port activation RAM, with a per-entry
// valid scoreboard that holds off reads of entries not yet written.
module hidden_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  hidden_ram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    WIN_WR = 1'b0,
    WIN_RD = 1'b1
  } winner_e;

  logic [DEPTH-1:0] valid_mask_q, valid_mask_d;
  logic [ADDR_W:0]  wr_count_q, wr_count_d;
  logic             all_written_q, all_written_d;
  logic             rd_valid_q, rd_valid_d;
  winner_e          last_winner_q, last_winner_d;

  logic wr_ok, rd_ok, tie, wr_gnt, rd_gnt;

  // A read only competes once its entry holds data for this inference.
  assign wr_ok  = bus.wr_req && !bus.layer_clr && !rst;
  assign rd_ok  = bus.rd_req && valid_mask_q[bus.rd_addr] && !bus.layer_clr && !rst;
  assign tie    = wr_ok && rd_ok;
  assign wr_gnt = wr_ok && (!rd_ok || last_winner_q == WIN_RD);
  assign rd_gnt = rd_ok && !wr_gnt;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    valid_mask_d  = valid_mask_q;
    wr_count_d    = wr_count_q;
    last_winner_d = last_winner_q;
    rd_valid_d    = rd_gnt;

    if (bus.layer_clr) begin
      valid_mask_d = '0;
      wr_count_d   = '0;
    end else if (wr_gnt) begin
      if (!valid_mask_q[bus.wr_addr]) begin
        wr_count_d = wr_count_q + 1'b1;
      end
      valid_mask_d[bus.wr_addr] = 1'b1;
    end

    // Fairness state only moves when both sides actually contended.
    if (tie) begin
      last_winner_d = wr_gnt ? WIN_WR : WIN_RD;
    end

    all_written_d = &valid_mask_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      valid_mask_q  <= '0;
      wr_count_q    <= '0;
      all_written_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      last_winner_q <= WIN_RD;
    end else begin
      valid_mask_q  <= valid_mask_d;
      wr_count_q    <= wr_count_d;
      all_written_q <= all_written_d;
      rd_valid_q    <= rd_valid_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign bus.wr_gnt      = wr_gnt;
  assign bus.rd_gnt      = rd_gnt;
  // A read return landing in a reset cycle is dropped.
  assign bus.rd_valid    = rd_valid_q && !rst;
  assign bus.rd_data     = bus.ram_q;
  assign bus.ram_we      = wr_gnt;
  assign bus.ram_addr    = wr_gnt ? bus.wr_addr : bus.rd_addr;
  assign bus.ram_data    = bus.wr_data;
  assign bus.wr_count    = wr_count_q;
  assign bus.all_written = all_written_q;
endmodule

// File: tb/tb_hidden_ram_ctrl.sv
// Bench for hidden_ram_ctrl: directed scenarios plus random traffic, checked
// against an array-based reference model and a read-return scoreboard.
module tb_hidden_ram_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hidden_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  hidden_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single-port RAM with registered address.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic [DATA_W-1:0] ram_q_r;
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_data;
    ram_q_r <= ram_mem[bus.ram_addr];
  end
  assign bus.ram_q = ram_q_r;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: which entries hold data, how many, and who gets a tie.
  bit              m_valid [DEPTH];
  int              m_count  = 0;
  bit              m_wr_pri = 1'b1;
  logic [DATA_W-1:0] m_mem [DEPTH];

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  always @(negedge clk) begin : model
    bit we, re, ew, er, full;
    we = bus.wr_req && !bus.layer_clr && !rst;
    re = bus.rd_req && m_valid[bus.rd_addr] && !bus.layer_clr && !rst;
    ew = we && (!re || m_wr_pri);
    er = re && !ew;
    full = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) full = 1'b0;

    check("wr_gnt", bus.wr_gnt, ew);
    check("rd_gnt", bus.rd_gnt, er);
    check("ram_we", bus.ram_we, ew);
    if (ew) check("ram_addr_wr", bus.ram_addr, bus.wr_addr);
    if (er) check("ram_addr_rd", bus.ram_addr, bus.rd_addr);
    check("wr_count", bus.wr_count, m_count);
    check("all_written", bus.all_written, full);

    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_count  = 0;
      m_wr_pri = 1'b1;
    end else if (bus.layer_clr) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_count = 0;
    end else begin
      if (we && re) m_wr_pri = !ew;
      if (ew) begin
        if (!m_valid[bus.wr_addr]) m_count++;
        m_valid[bus.wr_addr] = 1'b1;
        m_mem[bus.wr_addr]   = bus.wr_data;
      end
      if (er) exp_q.push_back('{data: m_mem[bus.rd_addr], due: cyc + 1});
    end
  end

  // Read-return monitor: every granted read must come back exactly one cycle later.
  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      if (rst) begin
        check("rd_valid_in_reset", bus.rd_valid, 1'b0);
      end else begin
        check("rd_valid", bus.rd_valid, 1'b1);
        if (bus.rd_valid) check("rd_data", bus.rd_data, e.data);
      end
    end else begin
      check("rd_valid_idle", bus.rd_valid, 1'b0);
    end
  end

  bit s_wg, s_rg;

  task automatic step();
    @(negedge clk);
    s_wg = bus.wr_gnt;
    s_rg = bus.rd_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_granted();
    if (s_wg) bus.wr_req = 1'b0;
    if (s_rg) bus.rd_req = 1'b0;
  endtask

  task automatic run_both(input bit do_w, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                          input bit do_r, input logic [ADDR_W-1:0] ra, input int budget);
    int n = 0;
    if (do_w) begin bus.wr_req = 1'b1; bus.wr_addr = wa; bus.wr_data = wd; end
    if (do_r) begin bus.rd_req = 1'b1; bus.rd_addr = ra; end
    while ((bus.wr_req || bus.rd_req) && n < budget) begin
      step();
      n++;
      drop_granted();
    end
    check("handshake_in_budget", {bus.wr_req, bus.rd_req}, 2'b00);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.layer_clr = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic stream(input int cycles, input int w_pct, input int r_pct, input int c_pct,
                        input bit r_fixed, input logic [ADDR_W-1:0] r_addr);
    repeat (cycles) begin
      bus.layer_clr = ($urandom_range(99) < c_pct);
      if (!bus.wr_req && $urandom_range(99) < w_pct) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'($urandom_range(DEPTH - 1));
        bus.wr_data = DATA_W'($urandom);
      end
      if (!bus.rd_req && $urandom_range(99) < r_pct) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = r_fixed ? r_addr : ADDR_W'($urandom_range(DEPTH - 1));
      end
      step();
      drop_granted();
    end
    bus.layer_clr = 1'b0;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    bus.layer_clr = 1'b0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    do_reset(3);

    // Basic write then read.
    run_both(1'b1, 5'd3, 8'hA5, 1'b0, 5'd0, 10);
    run_both(1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 10);
    step();

    // Read of an unwritten entry waits for the write.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd7;
    repeat (5) begin step(); drop_granted(); end
    run_both(1'b1, 5'd7, 8'h3C, 1'b0, 5'd0, 10);
    step();

    // Continuous contention after reset: W, R, W, R ...
    do_reset(2);
    run_both(1'b1, 5'd3, 8'h5A, 1'b0, 5'd0, 10);
    stream(12, 100, 100, 0, 1'b1, 5'd3);
    step();

    // Fill every entry, then overwrite one.
    bus.layer_clr = 1'b1;
    step();
    bus.layer_clr = 1'b0;
    for (int a = 0; a < DEPTH; a++) run_both(1'b1, ADDR_W'(a), DATA_W'(a), 1'b0, 5'd0, 10);
    step();
    run_both(1'b1, 5'd0, 8'hEE, 1'b0, 5'd0, 10);
    run_both(1'b0, 5'd0, 8'h00, 1'b1, 5'd17, 10);
    run_both(1'b0, 5'd0, 8'h00, 1'b1, 5'd0, 10);
    step();

    // Clear with a write pending: no grant that cycle, grant right after.
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 5'd9;
    bus.wr_data   = 8'h99;
    bus.layer_clr = 1'b1;
    step();
    drop_granted();
    bus.layer_clr = 1'b0;
    run_both(1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 10);
    step();

    // Reset in the cycle after a read grant drops the return.
    run_both(1'b1, 5'd5, 8'h55, 1'b0, 5'd0, 10);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd5;
    step();
    drop_granted();
    do_reset(1);
    step();
    step();

    // Random traffic with occasional clears.
    stream(3000, 60, 60, 2, 1'b0, 5'd0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hidden_ram_ctrl.md
# hidden_ram_ctrl

Arbiter and scoreboard for the 32×8 hidden-unit activation RAM. It shares the RAM's single port between two requesters:
- the hidden-layer compute engine, which writes activations;
- the output-layer engine, which reads them back.

It tracks which entries hold valid data for the current inference. A read of an entry that has not been written since the last clear is held off until that entry is written.

## Interface
Parameters:
- DATA_W, 8, activation width; matches the RAM word width.
- ADDR_W, 5, RAM address width; depth is 2**ADDR_W = 32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- layer_clr  in  1  one-cycle pulse; clears the valid scoreboard at the start of a new inference.
- wr_req  in  1  writer request; held with wr_addr and wr_data until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  combinational; high in the cycle the write is issued to the RAM.
- rd_req  in  1  reader request; held with rd_addr until rd_gnt.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  combinational; high in the cycle the read address is issued to the RAM.
- rd_valid  out  1  registered; one-cycle pulse in the cycle after rd_gnt.
- rd_data  out  DATA_W  equals ram_q; meaningful only while rd_valid is high.
- ram_data  out  DATA_W  to RAM data input.
- ram_addr  out  ADDR_W  to RAM address input.
- ram_we  out  1  to RAM write enable.
- ram_q  in  DATA_W  from RAM q. The RAM registers its address, so q reflects the address presented one cycle earlier.
- wr_count  out  ADDR_W+1  number of distinct entries written since the last clear, range 0..32.
- all_written  out  1  high when all 32 scoreboard bits are set.

## Operation
Scoreboard:
- valid_mask is 32 bits. A granted write sets bit wr_addr.
- wr_count increments only when a granted write targets an address whose bit was 0.
- Overwriting an entry that is already valid is allowed and leaves wr_count unchanged.

Read eligibility:
- rd_ok = rd_req && valid_mask[rd_addr].
- A read of an unwritten entry stays pending, with no grant and no error, until that entry is written.

Arbitration: round-robin between the writer and an eligible reader.
- One-bit last_winner register; the requester that did not win most recently has priority on a tie.
- last_winner updates only on a tie, where both requesters are eligible in the same cycle.

Grant rules:
- Only one requester is granted per cycle.
- A lone eligible requester is always granted.
- While layer_clr is high, wr_gnt = rd_gnt = 0, and the clear takes effect at the clock edge.

RAM port muxing (combinational):
- On a write grant: ram_addr = wr_addr, ram_data = wr_data, ram_we = 1.
- Otherwise: ram_addr = rd_addr, ram_we = 0, ram_data = wr_data.

Read-after-write in the same cycle, same address, bit still 0:
- Only the write is eligible and granted.
- The read becomes eligible in the next cycle.
- The RAM returns the new data.

## Timing
- Write latency: data is in the RAM at the clock edge that ends the wr_gnt cycle. valid_mask, wr_count and all_written update at that same edge.
- Read latency: rd_gnt in cycle N gives rd_valid = 1 in cycle N+1, with rd_data = ram_q holding the contents of rd_addr as of the end of cycle N.
- Throughput: one access per cycle. Back-to-back reads produce back-to-back rd_valid pulses.
- Reset values: valid_mask = 0, wr_count = 0, all_written = 0, rd_valid = 0, last_winner = reader (so the writer wins the first tie).
- Reset does not clear RAM contents.
- Mid-operation reset: a rd_valid due in the next cycle is suppressed, and the scoreboard is cleared.
- layer_clr behaves like rst for the scoreboard only; last_winner is kept. A rd_valid already pending from the previous cycle is still delivered.
- all_written is registered, derived from the next value of valid_mask.
- No wrap of wr_count past 32 is possible.

## Test plan
- Reset, then write addr 3 = 0xA5 → wr_gnt in the same cycle, wr_count = 1 next cycle. Then read addr 3 → rd_valid one cycle after rd_gnt with rd_data = 0xA5.
- Read addr 7 before it is written → rd_gnt stays 0 for 5 cycles. Write 7 = 0x3C → rd_gnt in the following cycle, then rd_valid with 0x3C.
- Writer and reader (on a valid address) both request continuously → grants alternate W, R, W, R starting with W after reset. Exactly one grant per cycle.
- Write all 32 addresses with data = addr → all_written rises the cycle after the 32nd grant, wr_count = 32. Rewrite addr 0 → wr_count stays 32.
- layer_clr with wr_req pending → no grant that cycle, wr_count = 0 and all_written = 0 next cycle. The write is granted the cycle after.
- rst asserted in the cycle after a rd_gnt → rd_valid stays 0 and the scoreboard reads empty.
